// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV32_SIGNED_EN for two's-complement operands (sign fix-up on the DONE-entry register).
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        dz_q, dz_d;

  logic [32:0] r_shift, trial;
  logic [31:0] r_next, q_next;
  logic [31:0] mag_a, mag_b, res_q, res_r;

`ifdef DIV32_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  always_comb begin
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    res_q = neg_q_q ? (32'd0 - q_next) : q_next;
    res_r = neg_r_q ? (32'd0 - r_next) : r_next;
  end
`else
  always_comb begin
    mag_a = a;
    mag_b = b;
    res_q = q_next;
    res_r = r_next;
  end
`endif

  always_comb begin
    // R is shifted into 33 bits so divisors above 2^31 never lose the carried-out bit
    r_shift = {rem_q, quo_q[31]};
    trial   = r_shift - {1'b0, divisor_q};
    if (!trial[32]) begin
      r_next = trial[31:0];
      q_next = {quo_q[30:0], 1'b1};
    end else begin
      r_next = r_shift[31:0];
      q_next = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
`ifdef DIV32_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (b == 32'd0) begin
            state_d     = ST_DONE;
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = a;
            dz_d        = 1'b1;
          end else begin
            state_d   = ST_BUSY;
            divisor_d = mag_b;
            quo_d     = mag_a;
            rem_d     = 32'd0;
            count_d   = 5'd0;
`ifdef DIV32_SIGNED_EN
            neg_q_d   = a[31] ^ b[31];
            neg_r_d   = a[31];
`endif
          end
        end
      end
      ST_BUSY: begin
        rem_d   = r_next;
        quo_d   = q_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d     = ST_DONE;
          quotient_d  = res_q;
          remainder_d = res_r;
          dz_d        = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= 5'd0;
      divisor_q   <= 32'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      dz_q        <= 1'b0;
`ifdef DIV32_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
`ifdef DIV32_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign done      = (state_q == ST_DONE);
  assign dz        = dz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
